// File: rtl/medidor_eco_hcsr04.sv
// HC-SR04 front end: fires the trigger pulse, times the echo and converts it to rounded BCD centimetres.
// The result is presented with a one-cycle pronto strobe; no response or an overlong echo gives a timeout strobe.
module medidor_eco_hcsr04 #(
    parameter int CICLOS_TRIGGER = 500,
    parameter int CICLOS_CM      = 2941,
    parameter int TIMEOUT_CICLOS = 1_900_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        timeout,
    output logic [3:0]  db_estado
);

    localparam int TRIG_W = $clog2(CICLOS_TRIGGER + 1);
    localparam int TICK_W = $clog2(CICLOS_CM);
    localparam int TO_W   = $clog2(TIMEOUT_CICLOS + 1);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        PREPARA   = 4'd1,
        TRIGGER   = 4'd2,
        ESPERA    = 4'd3,
        MEDE      = 4'd4,
        ARREDONDA = 4'd5,
        ARMAZENA  = 4'd6,
        FINAL     = 4'd7,
        ERRO      = 4'd8
    } estado_t;

    estado_t           estado, proximo;
    logic              echo_meta, echo_s;
    logic [TRIG_W-1:0] trig_cnt;
    logic [TICK_W-1:0] tick;
    logic [TO_W-1:0]   to_cnt;
    logic [11:0]       cm;

    // BCD increment that holds at 999 instead of rolling over to 000.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] c, d, u;
        {c, d, u} = v;
        if (v == 12'h999) return v;
        if (u != 4'd9) begin
            u = u + 4'd1;
        end else begin
            u = 4'd0;
            if (d != 4'd9) begin
                d = d + 4'd1;
            end else begin
                d = 4'd0;
                c = c + 4'd1;
            end
        end
        return {c, d, u};
    endfunction

    logic to_fim;
    assign to_fim = (to_cnt == TO_W'(TIMEOUT_CICLOS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= INICIAL;
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            trig_cnt  <= '0;
            tick      <= '0;
            to_cnt    <= '0;
            cm        <= 12'h000;
            medida    <= 12'h000;
        end else begin
            estado    <= proximo;
            echo_meta <= echo;
            echo_s    <= echo_meta;
            case (estado)
                PREPARA: begin
                    trig_cnt <= '0;
                    tick     <= '0;
                    to_cnt   <= '0;
                    cm       <= 12'h000;
                end
                TRIGGER: trig_cnt <= trig_cnt + TRIG_W'(1);
                ESPERA, MEDE: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    // Ticks accumulate modulo one centimetre; each wrap carries into the BCD count.
                    if (echo_s) begin
                        if (tick == TICK_W'(CICLOS_CM - 1)) begin
                            tick <= '0;
                            cm   <= bcd_inc(cm);
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end
                end
                ARREDONDA: if (tick >= TICK_W'(CICLOS_CM / 2)) cm <= bcd_inc(cm);
                ARMAZENA:  medida <= cm;
                default: ;
            endcase
        end
    end

    always_comb begin
        proximo   = estado;
        trigger   = 1'b0;
        pronto    = 1'b0;
        timeout   = 1'b0;
        db_estado = estado;
        case (estado)
            INICIAL:   if (medir) proximo = PREPARA;
            PREPARA:   proximo = TRIGGER;
            TRIGGER: begin
                trigger = 1'b1;
                if (trig_cnt == TRIG_W'(CICLOS_TRIGGER - 1)) proximo = ESPERA;
            end
            ESPERA: begin
                if (to_fim)      proximo = ERRO;
                else if (echo_s) proximo = MEDE;
            end
            // Echo fall takes priority over a timeout expiring on the same cycle.
            MEDE: begin
                if (!echo_s)     proximo = ARREDONDA;
                else if (to_fim) proximo = ERRO;
            end
            ARREDONDA: proximo = ARMAZENA;
            ARMAZENA:  proximo = FINAL;
            FINAL: begin
                pronto  = 1'b1;
                proximo = INICIAL;
            end
            ERRO: begin
                timeout = 1'b1;
                proximo = INICIAL;
            end
            default:   proximo = INICIAL;
        endcase
    end

endmodule
